// File: rtl/mac_pkg.sv
// Shared widths, width helpers and the register bundles of the MAC accumulator.
// The struct fields are sized from the package defaults used by mac_accumulator.
package mac_pkg;

    localparam int MAC_P     = 8;
    localparam int MAC_GUARD = 8;

    function automatic int acc_width(input int p, input int guard);
        return 2 * p + guard;
    endfunction

    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int MAC_ACC_W = acc_width(MAC_P, MAC_GUARD);
    localparam int MAC_CNT_W = cnt_width(16);

    typedef struct packed {
        logic [MAC_P-1:0] a;
        logic [MAC_P-1:0] b;
        logic             last;
    } s1_t;

    typedef struct packed {
        logic [MAC_ACC_W-1:0] acc;
        logic [MAC_CNT_W-1:0] count;
        logic                 overflow;
    } res_t;

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned P x P multiplier with a selectable architecture.
// ARCH_TYPE 0 is the plain operator; any other value uses a carry-save array.
module multiplier #(
    parameter int PARALLELISM = 8,
    parameter int ARCH_TYPE   = 2
) (
    input  logic [PARALLELISM-1:0]   a,
    input  logic [PARALLELISM-1:0]   b,
    output logic [2*PARALLELISM-1:0] product
);

    localparam int W = 2 * PARALLELISM;

    generate
        if (ARCH_TYPE == 0) begin : g_behavioural
            assign product = W'(a) * W'(b);
        end else begin : g_csa
            logic [W-1:0] s;
            logic [W-1:0] c;
            logic [W-1:0] pp;
            logic [W-1:0] ns;

            // Partial products are folded into a redundant sum/carry pair; one final add resolves it.
            always_comb begin
                s  = '0;
                c  = '0;
                pp = '0;
                ns = '0;
                for (int i = 0; i < PARALLELISM; i++) begin
                    pp = (W'(a) & {W{b[i]}}) << i;
                    ns = s ^ c ^ pp;
                    c  = ((s & c) | (s & pp) | (c & pp)) << 1;
                    s  = ns;
                end
                product = s + c;
            end
        end
    endgenerate

endmodule

// File: rtl/mac_accumulator.sv
// Pipelined multiply-accumulate: operand register, multiplier, product register,
// then a per-frame accumulator that hands one result per frame downstream.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PARALLELISM = MAC_P,
    parameter int ARCH_TYPE   = 2,
    parameter int ACC_GUARD   = MAC_GUARD,
    parameter int CNT_W       = MAC_CNT_W
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [PARALLELISM-1:0]                        in_multiplicand,
    input  logic [PARALLELISM-1:0]                        in_multiplier,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [acc_width(PARALLELISM, ACC_GUARD)-1:0]  out_acc,
    output logic [cnt_width(CNT_W)-1:0]                   out_count,
    output logic                                          out_overflow
);

    localparam int ACC_W = acc_width(PARALLELISM, ACC_GUARD);
    localparam int PW    = 2 * PARALLELISM;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid
    // never depends on ready, and the payload holds while valid && !ready.
    logic             adv;
    s1_t              s1;
    logic             s1_valid;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    s2_prod;
    logic             s2_valid;
    logic             s2_last;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt_acc;
    logic             ovf_acc;
    logic             first;
    res_t             res;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;

    // The stall is global: the whole pipeline freezes while a result waits.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    multiplier #(
        .PARALLELISM (PARALLELISM),
        .ARCH_TYPE   (ARCH_TYPE)
    ) u_mult (
        .a       (s1.a),
        .b       (s1.b),
        .product (prod)
    );

    always_comb begin
        acc_base = '0;
        if (!first) acc_base = acc;
        sum      = {1'b0, acc_base} + (ACC_W + 1)'(s2_prod);
        ovf_next = (!first && ovf_acc) || sum[ACC_W];
        if (first)         cnt_next = CNT_W'(1);
        else if (&cnt_acc) cnt_next = cnt_acc;
        else               cnt_next = cnt_acc + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            acc       <= '0;
            cnt_acc   <= '0;
            ovf_acc   <= 1'b0;
            first     <= 1'b1;
            res       <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt_acc   <= '0;
            ovf_acc   <= 1'b0;
            first     <= 1'b1;
            res       <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) s1 <= '{a: in_multiplicand, b: in_multiplier, last: in_last};
            s2_valid <= s1_valid;
            s2_prod  <= prod;
            s2_last  <= s1.last;
            if (out_ready) out_valid <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    res       <= '{acc: sum[ACC_W-1:0], count: cnt_next, overflow: ovf_next};
                    out_valid <= 1'b1;
                    first     <= 1'b1;
                end else begin
                    acc     <= sum[ACC_W-1:0];
                    cnt_acc <= cnt_next;
                    ovf_acc <= ovf_next;
                    first   <= 1'b0;
                end
            end
        end
    end

    assign out_acc      = res.acc;
    assign out_count    = res.count;
    assign out_overflow = res.overflow;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomised and directed bench for mac_accumulator against a frame-level sum model.
module tb_mac_accumulator;

    localparam int P     = 8;
    localparam int ACC_W = 24;
    localparam int CNT_W = 16;
    localparam int RW    = 1 + CNT_W + ACC_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [P-1:0]     in_multiplicand;
    logic [P-1:0]     in_multiplier;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int checks    = 0;
    int errors    = 0;
    int ready_pct = 100;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] obs_q[$];
    longint        frame_sum = 0;
    int            frame_cnt = 0;

    mac_accumulator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_acc         (out_acc),
        .out_count       (out_count),
        .out_overflow    (out_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A frame's result is its true product sum reduced to the output fields.
    function automatic logic [RW-1:0] frame_result(input longint s, input int c);
        logic             ov;
        logic [CNT_W-1:0] cc;
        logic [ACC_W-1:0] a;
        ov = (s >= (longint'(1) << ACC_W));
        cc = (c >= 65535) ? 16'hFFFF : CNT_W'(c);
        a  = ACC_W'(s);
        return {ov, cc, a};
    endfunction

    task automatic model_beat(input logic [P-1:0] a, input logic [P-1:0] b, input logic l);
        frame_sum += longint'(a) * longint'(b);
        frame_cnt++;
        if (l) begin
            exp_q.push_back(frame_result(frame_sum, frame_cnt));
            frame_sum = 0;
            frame_cnt = 0;
        end
    endtask

    task automatic take_result();
        logic [RW-1:0] obs;
        obs = {out_overflow, out_count, out_acc};
        obs_q.push_back(obs);
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", obs, exp_q.pop_front());
    endtask

    // One cycle: drive at the falling edge, observe what the next rising edge will transfer.
    task automatic tick(input logic v, input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic l, input logic clr, output logic took);
        @(negedge clk);
        in_valid        = v;
        in_multiplicand = a;
        in_multiplier   = b;
        in_last         = l;
        clear           = clr;
        out_ready       = ($urandom_range(0, 99) < ready_pct);
        #1;
        took = v && in_ready && !clr;
        if (out_valid && out_ready && !clr) take_result();
        if (took) model_beat(a, b, l);
        if (clr) begin
            frame_sum = 0;
            frame_cnt = 0;
        end
    endtask

    task automatic send_beat(input logic [P-1:0] a, input logic [P-1:0] b, input logic l);
        logic took;
        int   n;
        n = 0;
        do begin
            tick(1'b1, a, b, l, 1'b0, took);
            n++;
        end while (!took && n < 300);
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0, took);
    endtask

    task automatic wait_result(output int ticks);
        logic took;
        int   n0;
        n0    = obs_q.size();
        ticks = 0;
        while (obs_q.size() == n0 && ticks < 400) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, took);
            ticks++;
        end
        if (obs_q.size() == n0) check("result_timeout", 0, 1);
    endtask

    task automatic check_obs(input string tag, input int idx, input longint acc,
                             input int cnt, input logic ovf);
        logic [RW-1:0] r;
        if (idx >= obs_q.size()) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            r = obs_q[idx];
            check({tag, "_acc"}, r[ACC_W-1:0], acc);
            check({tag, "_count"}, r[ACC_W+CNT_W-1:ACC_W], cnt);
            check({tag, "_ovf"}, r[RW-1], ovf);
        end
    endtask

    initial begin
        int   lat;
        int   n0;
        logic took;

        rst_n           = 1'b0;
        clear           = 1'b0;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        in_last         = 1'b0;
        out_ready       = 1'b1;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_acc", out_acc, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_overflow", out_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat and its latency.
        ready_pct = 100;
        send_beat(8'h11, 8'h11, 1'b1);
        wait_result(lat);
        check("latency_ticks", lat, 3);
        check_obs("single", obs_q.size() - 1, 289, 1, 1'b0);

        // Three-beat frame; result valid for a single cycle.
        repeat (3) begin
            send_beat(8'd255, 8'd255, 1'b0);
        end
        send_beat(8'd0, 8'd0, 1'b1);
        wait_result(lat);
        check_obs("zero_tail", obs_q.size() - 1, 195075, 4, 1'b0);
        send_beat(8'd255, 8'd255, 1'b0);
        send_beat(8'd255, 8'd255, 1'b0);
        send_beat(8'd255, 8'd255, 1'b1);
        wait_result(lat);
        check_obs("three", obs_q.size() - 1, 195075, 3, 1'b0);
        idle(1);
        check("valid_one_cycle", out_valid, 0);

        // Accumulator wrap with sticky overflow, then a clean frame.
        for (int i = 0; i < 259; i++) send_beat(8'd255, 8'd255, i == 258);
        wait_result(lat);
        check_obs("overflow", obs_q.size() - 1, 64259, 259, 1'b1);
        send_beat(8'd3, 8'd4, 1'b1);
        wait_result(lat);
        check_obs("after_ovf", obs_q.size() - 1, 12, 1, 1'b0);

        // Backpressure: three single-beat frames queued behind a stalled output.
        idle(2);
        n0        = obs_q.size();
        ready_pct = 0;
        send_beat(8'd2, 8'd3, 1'b1);
        send_beat(8'd4, 8'd5, 1'b1);
        send_beat(8'd6, 8'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_acc", out_acc, 6);
        end
        ready_pct = 100;
        for (int i = 0; i < 3; i++) wait_result(lat);
        check_obs("bp0", n0, 6, 1, 1'b0);
        check_obs("bp1", n0 + 1, 20, 1, 1'b0);
        check_obs("bp2", n0 + 2, 42, 1, 1'b0);

        // Mid-frame clear discards the partial frame.
        idle(2);
        n0 = obs_q.size();
        send_beat(8'd10, 8'd10, 1'b0);
        send_beat(8'd10, 8'd10, 1'b0);
        idle(3);
        tick(1'b1, 8'd50, 8'd50, 1'b1, 1'b1, took);
        send_beat(8'd1, 8'd1, 1'b1);
        wait_result(lat);
        idle(4);
        check("clear_result_count", obs_q.size() - n0, 1);
        check_obs("clear", n0, 1, 1, 1'b0);

        // Randomised traffic with random output backpressure.
        ready_pct = 70;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_beat(P'($urandom_range(0, 255)), P'($urandom_range(0, 255)),
                      (i == 299) || ($urandom_range(0, 3) == 0));
        end
        ready_pct = 100;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
        check("random_drain", exp_q.size(), 0);

        // Asynchronous reset while a result is held.
        ready_pct = 0;
        send_beat(8'd5, 8'd5, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) idle(1);
        check("rst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_acc", out_acc, 0);
        check("rst_async_count", out_count, 0);
        check("rst_async_ovf", out_overflow, 0);
        check("rst_async_in_ready", in_ready, 1);
        exp_q.delete();
        frame_sum = 0;
        frame_cnt = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        ready_pct = 100;
        send_beat(8'hFF, 8'h01, 1'b1);
        wait_result(lat);
        check_obs("post_reset", obs_q.size() - 1, 255, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Pipelined multiply-accumulate stage wrapped around the team's combinational `multiplier` module.
- Accepts a stream of unsigned operand pairs through a valid/ready handshake, with frames delimited by `in_last`.
- Registers the operands ahead of the multiplier and registers the product behind it.
- Accumulates the products of each frame and presents one result per frame downstream, with the beat count and an overflow flag.

Parameters:
- PARALLELISM, 8, operand width in bits (P).
- ARCH_TYPE, 2, passed through to the `multiplier` architecture selector (2 = CSA).
- ACC_GUARD, 8, guard bits added above 2P; ACC_W = 2P + ACC_GUARD.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of the pipeline, accumulator and output.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  the block can accept an operand pair.
- in_multiplicand  in  P  unsigned operand A.
- in_multiplier  in  P  unsigned operand B.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  sum of the frame's products, modulo 2^ACC_W.
- out_count  out  CNT_W  beats in the frame; saturates at all-ones.
- out_overflow  out  1  a carry out of ACC_W occurred during the frame.

Behaviour:
- Reset: all outputs and internal registers go to 0 asynchronously while rst_n=0. After reset the first-beat flag is 1, so in_ready=1 and out_valid=0.
- Advance signal: adv = !(out_valid && !out_ready).
  - in_ready = adv.
  - When adv=0, S1, S2, the accumulator and the result registers all hold.
- S1 (input stage): on in_valid && in_ready, capture A, B and last, and set s1_valid. When adv=1 and there is no input, s1_valid is cleared. The multiplier is driven combinationally from the S1 registers.
- S2 (product stage): when adv=1, capture prod (2P bits), s1_valid and s1_last.
- Accumulate stage, when adv=1 and s2_valid:
  - sum = (first ? 0 : acc) + zero-extended prod, computed ACC_W+1 wide.
  - ovf = (first ? 0 : ovf_acc) | sum[ACC_W].
  - cnt = (first ? 1 : cnt_acc + 1), saturating.
  - If s2_last=0: acc, ovf_acc and cnt_acc take the new values; first = 0.
  - If s2_last=1: load the result registers (out_acc = sum[ACC_W-1:0], out_count, out_overflow); set out_valid = 1; set first = 1.
- Output handshake:
  - out_valid && out_ready with no new result in the same cycle: out_valid drops to 0 next cycle.
  - Same-cycle accept plus new result: out_valid stays 1 and the result registers are replaced.
  - out_acc, out_count and out_overflow are stable while out_valid && !out_ready.
- Latency: a beat accepted at edge N with in_last=1 produces out_valid=1 after edge N+2. Steady-state throughput is 1 beat per cycle when out_ready=1.
- Backpressure: the stall is global. The pipeline is only ever fully frozen, so no beat is dropped or duplicated.
- clear=1 at an edge:
  - s1_valid, s2_valid and out_valid go to 0.
  - acc, cnt_acc and ovf_acc go to 0; first = 1.
  - The input is not accepted that cycle (in_ready is still driven by adv, but the beat is discarded).
  - clear has priority over all other updates.
- Reset mid-frame: the partial frame is lost, and the next beat starts a new frame.
- Count wrap: cnt_acc sticks at 2^CNT_W-1. The accumulator wraps modulo 2^ACC_W, with out_overflow sticky for the frame.
- A frame with zero products still counts its beats (out_acc = 0).

Decomposition:
- Package mac_pkg:
  - ACC_W and CNT_W derivation functions.
  - typedef struct s1_t {a, b, last}.
  - typedef struct res_t {acc, count, overflow}.
- Sub-module: the existing `multiplier` (PARALLELISM, ARCH_TYPE) instantiated between S1 and S2. No further sub-modules.

Test Plan:
- Single beat: A=0x11, B=0x11, last=1, out_ready=1 -> out_valid after edge N+2; out_acc=289, out_count=1, out_overflow=0.
- Three-beat frame: (255,255)x3, last on the third beat -> out_acc=195075, out_count=3, out_overflow=0; out_valid high for exactly 1 cycle.
- Overflow: 259 beats of (255,255), last on beat 259 -> out_acc=64259 (16841475 mod 2^24), out_count=259, out_overflow=1. The next frame (3,4), last -> out_acc=12, out_overflow=0.
- Backpressure: back-to-back single-beat frames (2,3), (4,5), (6,7) with out_ready=0 for 5 cycles -> in_ready=0 while stalled; result 6 held stable; after release, results 6, 20, 42 arrive in order with none lost.
- Mid-frame clear: two beats of (10,10), then clear=1, then (1,1) with last -> out_acc=1, out_count=1; no result is emitted for the flushed beats.
- Reset mid-frame: assert rst_n=0 asynchronously between edges while out_valid=1 -> all outputs 0 immediately. After release, (0xFF,0x01) with last -> out_acc=255.
